// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, datapath
// select codes and the FSM state set.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } ctrl_state_t;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// Moore output decode for the multicycle controller. Only the FETCH write
// strobes and MEMWR completion look at mem_ready; reset blanks everything.
module mips_multicycle_ctrl_decode
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OPW     = 6,
  parameter int ALUOP_W = 2,
  parameter int STATE_W = 4
) (
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic               mem_ready,
  input  logic [OPW-1:0]     opcode,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               instr_done,
  output logic               illegal_op
);

  always_comb begin
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = PCSRC_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REGB;
    ALUOp      = ALUOP_ADD;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB    = SRCB_IMMSH;
          illegal_op = !op_supported(opcode);
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        MEMRD: IorD = 1'b1;
        MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        // Strobe held for the whole stall so the memory sees a stable request.
        MEMWR: begin
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUOp      = ALUOP_SUB;
          Branch     = 1'b1;
          PCSrc      = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          PCSrc      = PCSRC_JUMP;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: state register and next-state logic;
// control outputs come from the decode sub-module.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int OPW     = 6,
  parameter int ALUOP_W = 2,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPW-1:0]     opcode,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_n;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = FETCH;
    case (state)
      FETCH:  state_n = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_n = EXEC;
          OP_LW, OP_SW: state_n = MEMADR;
          OP_BEQ:       state_n = BRANCH;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JUMP;
          default:      state_n = FETCH;
        endcase
      end
      // IR still holds the instruction, so opcode distinguishes lw from sw here.
      MEMADR: state_n = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_n = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_n = mem_ready ? FETCH : MEMWR;
      EXEC:   state_n = ALUWB;
      ADDIEX: state_n = ADDIWB;
      default: state_n = FETCH;
    endcase
  end

  assign state_o = reset ? STATE_W'(FETCH) : state;

  mips_multicycle_ctrl_decode #(
    .OPW     (OPW),
    .ALUOP_W (ALUOP_W),
    .STATE_W (STATE_W)
  ) u_decode (
    .reset      (reset),
    .state      (state),
    .mem_ready  (mem_ready),
    .opcode     (opcode),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .instr_done (instr_done),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: instruction-level reference model
// feeds a per-cycle expectation queue, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       IorD, IRWrite, PCWrite, Branch, ALUSrcA, MemWrite, MemtoReg;
  logic       RegDst, RegWrite, instr_done, illegal_op;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPW(6), .ALUOP_W(2), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  typedef struct packed {
    logic       iord, irw, pcw, br;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb, aluop;
    logic       memw, m2r, rdst, regw, done, ill;
    logic [3:0] st;
  } outs_t;

  localparam logic [5:0] OPC_R = 6'b000000, OPC_LW = 6'b100011, OPC_SW = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100, OPC_ADDI = 6'b001000, OPC_J = 6'b000010;

  // Phase numbering is the documented state numbering, reported on state_o.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
  localparam int P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9;
  localparam int P_ADDIWB = 10, P_JUMP = 11;

  outs_t exp_q[$];
  int    exp_ph[$];
  int    total = 0;
  int    passed = 0;
  bit    aborted;
  int    abort_at;
  int    cyc_in;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t model(int ph, bit mr, logic [5:0] op, bit rst);
    outs_t o = '0;
    if (rst) return o;
    o.st = 4'(ph);
    case (ph)
      P_FETCH:  begin o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
      P_DECODE: begin
        o.srcb = 2'b11;
        o.ill  = !(op == OPC_R || op == OPC_LW || op == OPC_SW ||
                   op == OPC_BEQ || op == OPC_ADDI || op == OPC_J);
      end
      P_MEMADR: begin o.srca = 1'b1; o.srcb = 2'b10; end
      P_MEMRD:  o.iord = 1'b1;
      P_MEMWB:  begin o.m2r = 1'b1; o.regw = 1'b1; o.done = 1'b1; end
      P_MEMWR:  begin o.iord = 1'b1; o.memw = 1'b1; o.done = mr; end
      P_EXEC:   begin o.srca = 1'b1; o.aluop = 2'b10; end
      P_ALUWB:  begin o.rdst = 1'b1; o.regw = 1'b1; o.done = 1'b1; end
      P_BRANCH: begin
        o.srca = 1'b1; o.aluop = 2'b01; o.br = 1'b1; o.pcsrc = 2'b01; o.done = 1'b1;
      end
      P_ADDIEX: begin o.srca = 1'b1; o.srcb = 2'b10; end
      P_ADDIWB: begin o.regw = 1'b1; o.done = 1'b1; end
      P_JUMP:   begin o.pcsrc = 2'b10; o.pcw = 1'b1; o.done = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // One clock of stimulus; an instruction aborted by reset skips its remaining phases.
  task automatic cyc(input int ph, input bit mr, input logic [5:0] op);
    bit rst;
    if (aborted) return;
    rst = (cyc_in == abort_at);
    @(posedge clk);
    #1;
    reset = rst;
    mem_ready = mr;
    opcode = op;
    exp_q.push_back(model(ph, mr, op, rst));
    exp_ph.push_back(rst ? -1 : ph);
    cyc_in++;
    if (rst) aborted = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input int abort);
    aborted = 1'b0;
    cyc_in = 0;
    abort_at = abort;
    for (int i = 0; i < fstall; i++) cyc(P_FETCH, 1'b0, op);
    cyc(P_FETCH, 1'b1, op);
    cyc(P_DECODE, rb(), op);
    case (op)
      OPC_R:    begin cyc(P_EXEC, rb(), op); cyc(P_ALUWB, rb(), op); end
      OPC_LW: begin
        cyc(P_MEMADR, rb(), op);
        for (int i = 0; i < mstall; i++) cyc(P_MEMRD, 1'b0, op);
        cyc(P_MEMRD, 1'b1, op);
        cyc(P_MEMWB, rb(), op);
      end
      OPC_SW: begin
        cyc(P_MEMADR, rb(), op);
        for (int i = 0; i < mstall; i++) cyc(P_MEMWR, 1'b0, op);
        cyc(P_MEMWR, 1'b1, op);
      end
      OPC_BEQ:  cyc(P_BRANCH, rb(), op);
      OPC_ADDI: begin cyc(P_ADDIEX, rb(), op); cyc(P_ADDIWB, rb(), op); end
      OPC_J:    cyc(P_JUMP, rb(), op);
      default: ;
    endcase
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = rb();
    opcode = 6'($urandom);
    exp_q.push_back('0);
    exp_ph.push_back(-1);
  endtask

  always @(negedge clk) begin
    outs_t e, g;
    int ph;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      ph = exp_ph.pop_front();
      g = {IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
           MemWrite, MemtoReg, RegDst, RegWrite, instr_done, illegal_op, state_o};
      total++;
      if (g === e) passed++;
      else $display("FAIL ctrl_outputs t=%0t phase=%0d got=%h expected=%h", $time, ph, g, e);
    end
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    int         ab;
    ops = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J, 6'h3f, 6'h00};

    reset_cycle();
    reset_cycle();

    run_instr(OPC_R,    0, 0, -1);
    run_instr(OPC_LW,   0, 2, -1);
    run_instr(OPC_SW,   1, 1, -1);
    run_instr(OPC_BEQ,  0, 0, -1);
    run_instr(OPC_J,    0, 0, -1);
    run_instr(6'h3f,    0, 0, -1);
    run_instr(OPC_ADDI, 2, 0, -1);
    run_instr(OPC_SW,   0, 1, 3);
    run_instr(OPC_R,    0, 0, 2);
    run_instr(OPC_LW,   0, 1, 4);

    for (int n = 0; n < 250; n++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 7) op = 6'($urandom);
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(op,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 3)), ab);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
